// File: rtl/ibex_clk_gate_ctrl.sv
// Sleep/wake sequencer for the Ibex core clock gate: gates after an idle
// window, restores the clock on any wake source and acknowledges after a settle delay.
module ibex_clk_gate_ctrl #(
  parameter int unsigned IdleCycles = 4,
  parameter int unsigned WakeCycles = 2,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                core_sleep_i,
  input  logic                irq_pending_i,
  input  logic                debug_req_i,
  input  logic                gate_disable_i,
  output logic                clk_en_o,
  output logic                gated_o,
  output logic                wake_ack_o,
  output logic [CntWidth-1:0] gated_cycles_o,
  input  logic                cnt_clr_i
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IDLE  = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } state_e;

  localparam logic [7:0] IdleLoad = 8'(IdleCycles - 1);
  localparam logic [7:0] WakeLoad = 8'(WakeCycles - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                clk_en_q, clk_en_d;
  logic                gated_q, gated_d;
  logic                wake_ack_q, wake_ack_d;
  logic [CntWidth-1:0] gated_cycles_q;
  logic                wake, sleep;

  assign wake  = irq_pending_i | debug_req_i | gate_disable_i;
  assign sleep = core_sleep_i & ~wake;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      clk_en_q   <= 1'b1;
      gated_q    <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_en_q   <= clk_en_d;
      gated_q    <= gated_d;
      wake_ack_q <= wake_ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (sleep) begin
          cnt_d   = IdleLoad;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (!sleep) begin
          cnt_d   = '0;
          state_d = RUN;
        end else if (cnt_q == '0) begin
          state_d = GATED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GATED: begin
        if (wake) begin
          cnt_d   = WakeLoad;
          state_d = WAKE;
        end
      end
      WAKE: begin
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RUN;
      end
    endcase
  end

  // Outputs are decoded from the next state and then flopped, so the gate
  // latch sees a registered, glitch-free enable that tracks the state exactly.
  always_comb begin
    clk_en_d   = (state_d != GATED);
    gated_d    = (state_d == GATED);
    wake_ack_d = (state_q == WAKE) && (cnt_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      gated_cycles_q <= '0;
    end else if ((state_q == GATED) && (gated_cycles_q != '1)) begin
      gated_cycles_q <= gated_cycles_q + 1'b1;
    end
  end

  assign clk_en_o       = clk_en_q;
  assign gated_o        = gated_q;
  assign wake_ack_o     = wake_ack_q;
  assign gated_cycles_o = gated_cycles_q;

endmodule
